// File: rtl/scamp_pkg.sv
// Shared constants and types for the SCAMP micro-sequencer.
// Microinstruction encodings, control-bit positions and FSM states.
package scamp_pkg;

  localparam logic [15:0] FETCH0 = 16'h8020;
  localparam logic [15:0] FETCH1 = 16'hB440;
  localparam logic [15:0] NOP    = 16'h8000;

  localparam int EO_BAR = 15;
  localparam int RT     = 11;
  localparam int P_INC  = 10;

  localparam logic [2:0] T_LAST = 3'd7;

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/micro_sequencer.sv
// Micro-sequencer: HALT/RUN FSM, T-state counter and retire counter.
// Fetch microwords are built in; T2..T7 come from the microcode ROM.
module micro_sequencer
  import scamp_pkg::*;
(
  input  logic        clk,
  input  logic        reset_bar,
  input  logic        run,
  input  logic        step,
  input  logic [7:0]  opcode,
  output logic [10:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] uinstr,
  output logic [2:0]  tstate,
  output logic        halted,
  output logic        instr_done,
  output logic [15:0] retired
);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] tstate_nxt;
  logic       rt_hit;

  assign rom_addr = {opcode, tstate};
  assign halted   = (state == HALT);

  always_comb begin
    uinstr = NOP;
    if (state == RUN) begin
      unique case (tstate)
        3'd0:    uinstr = FETCH0;
        3'd1:    uinstr = FETCH1;
        default: uinstr = rom_data;
      endcase
    end
  end

  // Bit 11 is RT only for bus-transfer words; with EO_BAR low it is ALU NY.
  assign rt_hit     = uinstr[EO_BAR] & uinstr[RT];
  assign instr_done = (state == RUN) &
                      (rt_hit | (tstate == T_LAST));

  always_comb begin
    state_nxt  = state;
    tstate_nxt = tstate;
    unique case (1'b1)
      (state == HALT): begin
        tstate_nxt = 3'd0;
        if (run || step)
          state_nxt = RUN;
      end
      instr_done: begin
        tstate_nxt = 3'd0;
        state_nxt  = run ? RUN : HALT;
      end
      default: begin
        tstate_nxt = tstate + 3'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state  <= HALT;
      tstate <= 3'd0;
    end else begin
      state  <= state_nxt;
      tstate <= tstate_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar)
      retired <= 16'd0;
    else if (instr_done)
      retired <= retired + 16'd1;
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The module SHALL have ports: clk  in  1  system clock, all state changes on the rising edge.
REQ-002 The module SHALL have ports: reset_bar  in  1  asynchronous, active-low reset.
REQ-003 The module SHALL have ports: run  in  1  1 = free-run instructions; 0 = halt at the next instruction boundary.
REQ-004 The module SHALL have ports: step  in  1  single-cycle pulse; while halted, executes exactly one instruction.
REQ-005 The module SHALL have ports: opcode  in  8  IR high byte, stable from T2 onward.
REQ-006 The module SHALL have ports: rom_addr  out  11  microcode ROM address {opcode, tstate}.
REQ-007 The module SHALL have ports: rom_data  in  16  asynchronous microcode ROM read data.
REQ-008 The module SHALL have ports: uinstr  out  16  microinstruction to the control decoder.
REQ-009 The module SHALL have ports: tstate  out  3  current T-state.
REQ-010 The module SHALL have ports: halted  out  1  1 while in HALT.
REQ-011 The module SHALL have ports: instr_done  out  1  high during the last T-state of an instruction.
REQ-012 The module SHALL have ports: retired  out  16  count of completed instructions.
REQ-013 Clocking SHALL be one clock, clk; reset SHALL be asynchronous and active-low, reset_bar.

Function
REQ-014 States SHALL be HALT and RUN; tstate SHALL be a 3-bit counter, T0..T7.
REQ-015 In RUN, uinstr SHALL be FETCH0 = 0x8020 (PC out, MAR in) at T0, FETCH1 = 0xB440 (RAM out, IR in, P+) at T1, and rom_data at T2..T7.
REQ-016 In HALT, uinstr SHALL be NOP = 0x8000 and tstate SHALL hold at 0.
REQ-017 rom_addr SHALL equal {opcode, tstate}, combinational, in all states.
REQ-018 End of instruction SHALL be defined, in RUN only, as either (uinstr[15]=1 and uinstr[11]=1, i.e. RT) or tstate=7.
REQ-019 When uinstr[15]=0, bit 11 SHALL be treated as an ALU flag (NY) and SHALL NOT end the instruction.
REQ-020 instr_done SHALL be asserted combinationally during the end-of-instruction cycle.
REQ-021 At the end-of-instruction edge, tstate SHALL go to 0 and retired SHALL increment, wrapping from 0xFFFF to 0x0000.
REQ-022 On a non-final RUN edge, tstate SHALL increment by 1.
REQ-023 HALT->RUN SHALL occur on an edge where run=1 or step=1; the following cycle is T0.
REQ-024 At an end-of-instruction edge, the next state SHALL be RUN if run=1, else HALT.
REQ-025 A step-initiated instruction SHALL end in HALT unless run=1 at its final edge.
REQ-026 Changes to run mid-instruction SHALL never truncate the instruction.
REQ-027 step SHALL be ignored in RUN; if run and step are high simultaneously, run SHALL dominate.
REQ-028 halted SHALL equal (state == HALT).

Reset
REQ-029 While reset_bar=0, asynchronously: state=HALT, tstate=0, retired=0, uinstr=0x8000, instr_done=0, halted=1.
REQ-030 Reset asserted mid-instruction SHALL abandon the instruction immediately, without incrementing retired.
REQ-031 The first possible RUN cycle SHALL be the edge after reset_bar rises, with run=1.

Structure
REQ-032 The shared package scamp_pkg SHALL hold FETCH0, FETCH1, NOP, the uinstr bit-position constants (EO_BAR=15, RT=11, P+=10) and the state enum.
REQ-033 The block SHALL have no sub-module; it is a single FSM plus counters, 120-200 lines.

Verification
REQ-034 Reset, then run=1, opcode=0x12 -> uinstr 0x8020 at T0, 0xB440 at T1; rom_addr=0x092 at T2 with uinstr=rom_data.
REQ-035 ROM[0x093]=0x8800 (RT) -> instr_done=1 at T3; next cycle T0 with uinstr=0x8020; retired=1.
REQ-036 ROM[0x092..0x097]=0x0800 (ALU, bit 11 set) -> no early end; instr_done at T7; wrap to T0.
REQ-037 run dropped at T4 -> instruction completes, then halted=1 with uinstr=0x8000; one step pulse -> exactly one instruction (retired+1), then HALT.
REQ-038 reset_bar low at T5 -> same cycle tstate=0, uinstr=0x8000, retired=0, halted=1.
REQ-039 retired preloaded via 65535 instructions, then one more -> retired=0x0000.
